// File: rtl/operand_frame_loader_if.sv
// Byte-stream input and committed-vector output bundle for the operand frame loader.
interface operand_frame_loader_if #(
  parameter int unsigned ERR_W = 8
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      weights_q;
  logic [15:0]      inputs_q;
  logic [3:0]       out_tag;
  logic             out_valid;
  logic             out_ready;
  logic             frame_err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, weights_q, inputs_q, out_tag, out_valid, frame_err, err_count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, weights_q, inputs_q, out_tag, out_valid, frame_err, err_count
  );
endinterface

// File: rtl/operand_frame_loader.sv
// Assembles checksummed operand frames into 4x4-bit weight/input vectors and hands
// each committed vector downstream over a valid/ready handshake.
module operand_frame_loader #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ERR_W   = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  operand_frame_loader_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t           state;
  logic [1:0]       ftype;
  logic [3:0]       ftag;
  logic [7:0]       xor_acc;
  logic [1:0]       idx;
  logic [7:0]       tmo_cnt;
  logic [15:0]      shadow_w;
  logic [15:0]      shadow_i;
  logic [15:0]      weights_q;
  logic [15:0]      inputs_q;
  logic [3:0]       out_tag;
  logic             out_valid;
  logic             frame_err;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       din;
  logic             accept;
  logic             to_inputs;
  logic             last_byte;
  logic             tmo_hit;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign din       = bus.in_data;
  assign bus.in_ready = rst_n && (state != COMMIT);
  assign accept    = bus.in_valid && bus.in_ready;
  // Type bit 0 selects weights, bit 1 selects inputs; type 11 sends weights first.
  assign to_inputs = (ftype == 2'b10) || idx[1];
  assign last_byte = (ftype == 2'b11) ? (idx == 2'd3) : (idx == 2'd1);
  assign tmo_hit   = !accept && (tmo_cnt == TMO_LAST);

  // Shadow payload capture; only ever copied out on a good trailer.
  always_ff @(posedge clk) begin
    if (state == PAYLOAD && accept) begin
      if (to_inputs) begin
        if (idx[0]) shadow_i[15:8] <= din;
        else        shadow_i[7:0]  <= din;
      end else begin
        if (idx[0]) shadow_w[15:8] <= din;
        else        shadow_w[7:0]  <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ftype     <= 2'b00;
      ftag      <= 4'h0;
      xor_acc   <= 8'h00;
      idx       <= 2'd0;
      tmo_cnt   <= 8'd0;
      weights_q <= 16'h0000;
      inputs_q  <= 16'h0000;
      out_tag   <= 4'h0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (din[7:6] == 2'b00) begin
              frame_err <= 1'b1;
              err_count <= sat_inc(err_count);
            end else begin
              ftype   <= din[7:6];
              ftag    <= din[3:0];
              xor_acc <= din;
              idx     <= 2'd0;
              tmo_cnt <= 8'd0;
              state   <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (accept) begin
            xor_acc <= xor_acc ^ din;
            tmo_cnt <= 8'd0;
            idx     <= idx + 2'd1;
            if (last_byte) state <= TRAILER;
          end else if (tmo_hit) begin
            frame_err <= 1'b1;
            err_count <= sat_inc(err_count);
            tmo_cnt   <= 8'd0;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        TRAILER: begin
          if (accept) begin
            tmo_cnt <= 8'd0;
            if ((xor_acc ^ din) == 8'h00) begin
              if (ftype[0]) weights_q <= shadow_w;
              if (ftype[1]) inputs_q  <= shadow_i;
              out_tag   <= ftag;
              out_valid <= 1'b1;
              state     <= COMMIT;
            end else begin
              frame_err <= 1'b1;
              err_count <= sat_inc(err_count);
              state     <= IDLE;
            end
          end else if (tmo_hit) begin
            frame_err <= 1'b1;
            err_count <= sat_inc(err_count);
            tmo_cnt   <= 8'd0;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        COMMIT: begin
          if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.weights_q = weights_q;
  assign bus.inputs_q  = inputs_q;
  assign bus.out_tag   = out_tag;
  assign bus.out_valid = out_valid;
  assign bus.frame_err = frame_err;
  assign bus.err_count = err_count;
endmodule

// File: doc/operand_frame_loader.md
Name: operand_frame_loader

Overview:
- Upstream feeder for the 4-lane nibble dot-product/max-tracker stage.
- Accepts a byte stream of framed, checksummed operand updates and assembles the 16-bit weight vector (4×4-bit lanes) and the 16-bit input vector.
- Commits a vector only when its frame is valid, then presents it to the downstream stage with a valid/ready handshake.
- Counts and flags malformed, corrupt or stalled frames.

Parameters:
- TIMEOUT, 255: consecutive idle cycles allowed mid-frame before abort (1..255).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept; a byte is accepted when in_valid && in_ready.
- weights_q  out  16  committed weights; lane k = bits [4k+3:4k].
- inputs_q  out  16  committed inputs, same lane layout.
- out_tag  out  4  tag of the last committed frame.
- out_valid  out  1  committed vector pending for downstream.
- out_ready  in  1  downstream accepts the vector.
- frame_err  out  1  one-cycle pulse per rejected frame.
- err_count  out  ERR_W  saturating count of rejected frames.

Behaviour:
- Reset (rst_n low at clk edge):
  - weights_q, inputs_q, out_tag, err_count, frame_err and out_valid all go to 0.
  - FSM goes to IDLE; timeout counter and checksum are cleared.
  - in_ready is 0 while rst_n is low.
  - Reset mid-frame discards the partial frame; no error is counted.
- Frame format: header, payload, trailer.
  - Header bits [7:6] = type: 01 weights only, 10 inputs only, 11 weights then inputs, 00 illegal. Bits [5:4] are ignored. Bits [3:0] = tag.
  - Payload is 2 bytes per vector. The first byte carries lane0 (low nibble) and lane1 (high nibble); the second byte carries lane2 and lane3.
  - Trailer is valid when the XOR of header, all payload bytes and trailer equals 0x00.
- FSM states:
  - IDLE: in_ready=1. An accepted header with a legal type latches type and tag, seeds the running XOR and goes to PAYLOAD. An accepted header with type 00 stays in IDLE and counts as a rejected frame.
  - PAYLOAD: in_ready=1. Accepted bytes go into shadow registers (not the outputs) and update the XOR. After 2 bytes (types 01/10) or 4 bytes (type 11), go to TRAILER.
  - TRAILER: in_ready=1. On an accepted byte, a zero final XOR goes to COMMIT. A non-zero final XOR counts as a rejected frame and returns to IDLE.
  - COMMIT: in_ready=0.
    - On entry (the cycle after trailer acceptance), the shadow values are copied to the selected outputs only. Type 01 leaves inputs_q unchanged; type 10 leaves weights_q unchanged.
    - out_tag is updated and out_valid=1.
    - Outputs are held stable until out_valid && out_ready, after which out_valid=0 and the FSM returns to IDLE on the next cycle.
- Latency: out_valid rises exactly one cycle after the trailer handshake.
- Timeout:
  - In PAYLOAD/TRAILER, the counter increments on every cycle with no accepted byte and clears on every accepted byte.
  - When it reaches TIMEOUT, the frame is aborted to IDLE and counts as rejected.
  - The counter is idle in IDLE and COMMIT, so downstream backpressure never times out.
- Rejected frame handling:
  - frame_err pulses high for exactly the cycle after the rejecting event.
  - err_count increments by 1 and saturates at all-ones (no wrap).
  - Shadow registers are discarded and the outputs are untouched.
- in_valid held high in COMMIT: the byte is not consumed and is accepted in IDLE after the handshake.
- No output is ever updated by a partial or failed frame.

Test Plan:
- Type-11 frame: bytes C5,21,43,65,87,45 with in_valid continuous and out_ready=1 → one cycle after byte 45: out_valid=1, weights_q=0x4321, inputs_q=0x8765, out_tag=5; frame_err=0.
- Then a type-01 frame: bytes 40,FF,FF,40 → weights_q=0xFFFF, inputs_q stays 0x8765, out_tag=0.
- Bad checksum: bytes C5,21,43,65,87,46 → frame_err pulses once, err_count=1, out_valid stays 0, weights_q/inputs_q unchanged.
- Illegal header 0x0A, then a valid frame 80,34,12,A6 → err_count increments on 0x0A; inputs_q=0x1234 commits normally.
- TIMEOUT=4: header 0x43, one payload byte, then in_valid=0 for 4 cycles → abort, frame_err pulse, err_count+1, FSM in IDLE accepting the next header.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles after a commit → in_ready=0, outputs stable, no timeout; out_ready=1 → handshake, in_ready=1 the next cycle.
  - rst_n low mid-payload → all outputs 0, err_count 0, the next clean frame commits correctly.
